// File: rtl/mango2_timing_pkg.sv
// Mango2 master timing constants shared by the timing generator,
// the video scanner and the system testbench.
package mango2_timing_pkg;

    localparam int CYCLES_PER_LINE = 65;
    localparam int TICKS_PER_CYCLE = 14;
    localparam int LONG_EXTRA      = 2;
    localparam int LINES_PER_FRAME = 262;
    localparam int VISIBLE_LINES   = 192;
    localparam int HBLANK_CYCLES   = 25;

    localparam int HCOUNT_W = 7;
    localparam int VCOUNT_W = 9;
    localparam int SUB_W    = 4;

    localparam int TICKS_PER_LINE =
        CYCLES_PER_LINE * TICKS_PER_CYCLE + LONG_EXTRA;

    localparam logic [SUB_W-1:0] SUB_LAST =
        SUB_W'(TICKS_PER_CYCLE - 1);
    localparam logic [SUB_W-1:0] SUB_LAST_LONG =
        SUB_W'(TICKS_PER_CYCLE + LONG_EXTRA - 1);
    localparam logic [SUB_W-1:0] PHI0_RISE =
        SUB_W'(TICKS_PER_CYCLE / 2);

    localparam logic [HCOUNT_W-1:0] HCOUNT_LAST =
        HCOUNT_W'(CYCLES_PER_LINE - 1);
    localparam logic [HCOUNT_W-1:0] HBLANK_END =
        HCOUNT_W'(HBLANK_CYCLES);

    // q3 runs 4 high / 3 low twice per cycle; the two long-cycle
    // extension ticks stay low.
    function automatic logic q3_decode(input logic [SUB_W-1:0] sub);
        return (sub <= SUB_W'(3)) ||
               ((sub >= SUB_W'(7)) && (sub <= SUB_W'(10)));
    endfunction

endpackage

// File: rtl/apple_timing_gen.sv
// Master timing generator: CPU/PHI0/Q3/pixel enables plus the
// beam position (cycle within line, line within frame).
module apple_timing_gen
    import mango2_timing_pkg::*;
#(
    parameter int FRAME_LINES  = LINES_PER_FRAME,
    parameter int VBLANK_START = VISIBLE_LINES
) (
    input  logic                clk,
    input  logic                reset,
    output logic                cpu_en,
    output logic                phi0,
    output logic                q3,
    output logic                pixel_en,
    output logic                long_cycle,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                hblank,
    output logic                vblank,
    output logic                frame_start
);

    localparam logic [VCOUNT_W-1:0] VCOUNT_LAST =
        VCOUNT_W'(FRAME_LINES - 1);
    localparam logic [VCOUNT_W-1:0] VBLANK_LINE =
        VCOUNT_W'(VBLANK_START);

    logic [SUB_W-1:0] sub;
    logic [SUB_W-1:0] sub_last;
    logic             cyc_end;
    logic             line_end;
    logic             frame_end;

    // Wrap compares use >= so any out-of-range count falls back to 0.
    always_comb begin
        long_cycle = (hcount == HCOUNT_LAST);
        sub_last   = long_cycle ? SUB_LAST_LONG : SUB_LAST;
        cyc_end    = (sub >= sub_last);
        line_end   = cyc_end && (hcount >= HCOUNT_LAST);
        frame_end  = line_end && (vcount >= VCOUNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub         <= '0;
            hcount      <= '0;
            vcount      <= '0;
            pixel_en    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_en    <= ~pixel_en;
            frame_start <= frame_end;
            if (cyc_end) begin
                sub    <= '0;
                hcount <= line_end ? '0 : hcount + 1'b1;
                if (line_end)
                    vcount <= frame_end ? '0 : vcount + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

    always_comb begin
        cpu_en = cyc_end;
        phi0   = (sub >= PHI0_RISE);
        q3     = q3_decode(sub);
        hblank = (hcount < HBLANK_END);
        vblank = (vcount >= VBLANK_LINE);
    end

endmodule

// File: tb/tb_apple_timing_gen.sv
// Randomized-reset bench for apple_timing_gen against a tick-count
// reference model; a second instance uses a short frame.
module tb_apple_timing_gen;

    localparam int TPL     = 912;
    localparam int LINES_A = 262;
    localparam int VIS_A   = 192;
    localparam int LINES_B = 5;
    localparam int VIS_B   = 3;
    localparam int FRAME_B = LINES_B * TPL;

    logic clk = 1'b0;
    logic reset;

    logic       en_a, phi_a, q3_a, pix_a, lc_a, hb_a, vb_a, fs_a;
    logic [6:0] h_a;
    logic [8:0] v_a;
    logic       en_b, phi_b, q3_b, pix_b, lc_b, hb_b, vb_b, fs_b;
    logic [6:0] h_b;
    logic [8:0] v_b;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int n_en, n_pix, n_long, n_phil;
    int first_en, last_fs;

    always #5 clk = ~clk;

    apple_timing_gen dut_a (
        .clk(clk), .reset(reset),
        .cpu_en(en_a), .phi0(phi_a), .q3(q3_a),
        .pixel_en(pix_a), .long_cycle(lc_a),
        .hcount(h_a), .vcount(v_a),
        .hblank(hb_a), .vblank(vb_a), .frame_start(fs_a)
    );

    apple_timing_gen #(
        .FRAME_LINES(LINES_B), .VBLANK_START(VIS_B)
    ) dut_b (
        .clk(clk), .reset(reset),
        .cpu_en(en_b), .phi0(phi_b), .q3(q3_b),
        .pixel_en(pix_b), .long_cycle(lc_b),
        .hcount(h_b), .vcount(v_b),
        .hblank(hb_b), .vblank(vb_b), .frame_start(fs_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%h exp=%h",
                     tag, t, got, exp);
        end
    endtask

    // Expected outputs from the tick count since reset alone.
    function automatic logic [31:0] model(input int tk,
                                          input int lines,
                                          input int vis);
        int p, ln, h, s, last;
        logic en, ph, q, px, lc, hb, vb, fs;
        p  = tk % TPL;
        ln = (tk / TPL) % lines;
        if (p >= 64 * 14) begin
            h = 64;
            s = p - 64 * 14;
        end else begin
            h = p / 14;
            s = p % 14;
        end
        last = (h == 64) ? 15 : 13;
        en = (s == last);
        ph = (s >= 7);
        q  = (s <= 3) || (s >= 7 && s <= 10);
        px = (tk % 2) == 1;
        lc = (h == 64);
        hb = (h < 25);
        vb = (ln >= vis);
        fs = (tk > 0) && (tk % (lines * TPL) == 0);
        return {8'd0, en, ph, q, px, lc, hb, vb, fs,
                7'(h), 9'(ln)};
    endfunction

    task automatic compare_all();
        int p;
        check("bus_a",
              {8'd0, en_a, phi_a, q3_a, pix_a, lc_a,
               hb_a, vb_a, fs_a, h_a, v_a},
              model(t, LINES_A, VIS_A));
        check("bus_b",
              {8'd0, en_b, phi_b, q3_b, pix_b, lc_b,
               hb_b, vb_b, fs_b, h_b, v_b},
              model(t, LINES_B, VIS_B));
        p = t % TPL;
        if (p == 0) begin
            n_en = 0; n_pix = 0; n_long = 0; n_phil = 0;
        end
        n_en   += int'(en_a);
        n_pix  += int'(pix_a);
        n_long += int'(lc_a);
        n_phil += int'(lc_a && phi_a);
        if (p == TPL - 1) begin
            check("line_cpu_en", n_en, 65);
            check("line_pix_en", n_pix, 456);
            check("line_long", n_long, 16);
            check("long_phi0", n_phil, 9);
        end
        if (t == 0) first_en = 0;
        if (first_en == 0 && en_a) first_en = t + 1;
        if (t == 20) check("first_cpu_en", first_en, 14);
        if (t == 14) check("hcount_after", h_a, 1);
        if (t == 0) last_fs = 0;
        if (fs_b) begin
            check("frame_period", t - last_fs, FRAME_B);
            last_fs = t;
        end
    endtask

    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        t = r ? 0 : t + 1;
        compare_all();
    endtask

    initial begin
        int hold;
        logic hit;
        reset = 1'b1;
        repeat (3) begin
            step();
            check("rst_q3", q3_a, 1);
            check("rst_phi0", phi_a, 0);
        end
        reset = 1'b0;

        hit = 1'b0;
        for (int i = 0; i < 20000 && !hit; i++) begin
            step();
            if (t >= 3 * FRAME_B && t % TPL == 429) hit = 1'b1;
        end
        check("target_hit", hit, 1);
        check("target_h", h_a, 30);
        reset = 1'b1;
        step();
        check("rst_h", h_a, 0);
        check("rst_v", v_a, 0);
        reset = 1'b0;

        hold = 0;
        for (int i = 0; i < 30000; i++) begin
            if (hold > 0) begin
                reset = 1'b1;
                hold--;
            end else begin
                reset = 1'b0;
                if ($urandom_range(0, 2999) == 0)
                    hold = $urandom_range(1, 3);
            end
            step();
        end
        reset = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
